// File: rtl/spram_arbiter.sv
// Shares one spram port between video scan-out (priority) and CPU; acks are combinational, command is registered, reads complete 3 cycles after ack.
// No backpressure beyond the grant itself: a requester holds its request until acked, and the CPU wins after MAX_STREAK consecutive video grants.
module spram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_STREAK    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     vid_req,
    input  logic [ADDRESS_WIDTH-1:0] vid_address,
    output logic                     vid_ack,
    output logic                     vid_rvalid,
    output logic [DATA_WIDTH-1:0]    vid_rdata,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_data,
    output logic                     cpu_ack,
    output logic                     cpu_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,

    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_q
);

    localparam logic OWNER_VID = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

    typedef struct packed {
        logic vld;
        logic owner;
        logic is_read;
    } tag_t;

    logic [7:0] streak;
    logic       cpu_turn;
    tag_t       tag_s1;
    tag_t       tag_s2;
    logic       s2_vid_read;
    logic       s2_cpu_read;

    assign cpu_turn = (streak == 8'(MAX_STREAK));

    // Video wins ties until the CPU has watched MAX_STREAK video grants in a row.
    assign vid_ack = reset_n && vid_req && !(cpu_req && cpu_turn);
    assign cpu_ack = reset_n && cpu_req && (!vid_req || cpu_turn);

    assign s2_vid_read = tag_s2.vld && tag_s2.is_read && (tag_s2.owner == OWNER_VID);
    assign s2_cpu_read = tag_s2.vld && tag_s2.is_read && (tag_s2.owner == OWNER_CPU);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            streak      <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_we      <= 1'b0;
            tag_s1      <= '0;
            tag_s2      <= '0;
            vid_rvalid  <= 1'b0;
            vid_rdata   <= '0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            if (!cpu_req || cpu_ack) begin
                streak <= '0;
            end else if (vid_ack && !cpu_turn) begin
                streak <= streak + 8'd1;
            end

            if (cpu_ack) begin
                ram_address <= cpu_address;
                ram_data    <= cpu_data;
                ram_we      <= cpu_we;
            end else if (vid_ack) begin
                ram_address <= vid_address;
                ram_we      <= 1'b0;
            end else begin
                ram_we      <= 1'b0;
            end

            tag_s1.vld     <= vid_ack || cpu_ack;
            tag_s1.owner   <= cpu_ack ? OWNER_CPU : OWNER_VID;
            tag_s1.is_read <= vid_ack || (cpu_ack && !cpu_we);
            tag_s2         <= tag_s1;

            // ram_q carries the data for the stage-2 tag; writes never complete.
            vid_rvalid <= s2_vid_read;
            cpu_rvalid <= s2_cpu_read;
            if (s2_vid_read) begin
                vid_rdata <= ram_q;
            end
            if (s2_cpu_read) begin
                cpu_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int MAX = 4;

    logic          clock;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_address;
    logic          vid_ack;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_data;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    spram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_STREAK(MAX)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_rvalid  (vid_rvalid),
        .vid_rdata   (vid_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_ack     (cpu_ack),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM with registered q and write-through on writes.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clock) begin
        if (ram_we) begin
            ram_mem[ram_address] <= ram_data;
            ram_q                <= ram_data;
        end else begin
            ram_q <= ram_mem[ram_address];
        end
    end

    // Reference model: shadow memory plus a list of reads owed to each requester.
    typedef struct {
        int       due;
        bit       owner;
        logic [7:0] data;
    } cmp_t;

    cmp_t        pend[$];
    logic [7:0]  shadow [256];
    logic [7:0]  exp_vid_rdata;
    logic [7:0]  exp_cpu_rdata;
    logic [7:0]  exp_ram_addr;
    logic [7:0]  exp_ram_data;
    logic        exp_ram_we;
    int          vid_run;
    int          cyc;
    int          n_checks;
    int          n_pass;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input bit rn, input bit vr, input logic [7:0] va,
                        input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        output bit vg, output bit cg);
        bit   ev;
        bit   ec;
        cmp_t c;
        @(negedge clock);
        reset_n     = rn;
        vid_req     = vr;
        vid_address = va;
        cpu_req     = cr;
        cpu_we      = cw;
        cpu_address = ca;
        cpu_data    = cd;
        #1;
        cyc++;

        // CPU is owed the slot once video has taken MAX grants in a row while it waited.
        vg = 1'b0;
        cg = 1'b0;
        if (rn) begin
            if (vr && cr) begin
                if (vid_run >= MAX) cg = 1'b1;
                else vg = 1'b1;
            end else begin
                vg = vr;
                cg = cr;
            end
        end
        chk_eq("vid_ack", vid_ack, vg);
        chk_eq("cpu_ack", cpu_ack, cg);
        chk_eq("ram_we", ram_we, exp_ram_we);
        chk_eq("ram_address", ram_address, exp_ram_addr);
        chk_eq("ram_data", ram_data, exp_ram_data);

        ev = 1'b0;
        ec = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            c = pend.pop_front();
            if (c.owner) begin
                ec = 1'b1;
                exp_cpu_rdata = c.data;
            end else begin
                ev = 1'b1;
                exp_vid_rdata = c.data;
            end
        end
        chk_eq("vid_rvalid", vid_rvalid, ev);
        chk_eq("cpu_rvalid", cpu_rvalid, ec);
        chk_eq("vid_rdata", vid_rdata, exp_vid_rdata);
        chk_eq("cpu_rdata", cpu_rdata, exp_cpu_rdata);

        if (!rn) begin
            pend.delete();
            exp_vid_rdata = 8'h00;
            exp_cpu_rdata = 8'h00;
            exp_ram_addr  = 8'h00;
            exp_ram_data  = 8'h00;
            exp_ram_we    = 1'b0;
            vid_run       = 0;
        end else begin
            exp_ram_we = 1'b0;
            if (vg) begin
                c.due = cyc + 3; c.owner = 1'b0; c.data = shadow[va];
                pend.push_back(c);
                exp_ram_addr = va;
            end
            if (cg) begin
                exp_ram_addr = ca;
                exp_ram_data = cd;
                exp_ram_we   = cw;
                if (cw) begin
                    shadow[ca] = cd;
                end else begin
                    c.due = cyc + 3; c.owner = 1'b1; c.data = shadow[ca];
                    pend.push_back(c);
                end
            end
            if (!cr || cg) vid_run = 0;
            else if (vg && vid_run < MAX) vid_run++;
        end
    endtask

    task automatic idle(input int n);
        bit vg;
        bit cg;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, vg, cg);
    endtask

    task automatic traffic(input int n, input int vpct, input int cpct, input int rpct);
        bit         vr = 1'b0;
        bit         cr = 1'b0;
        bit         cw = 1'b0;
        bit         rn;
        bit         vg;
        bit         cg;
        logic [7:0] va = 8'h00;
        logic [7:0] ca = 8'h00;
        logic [7:0] cd = 8'h00;
        int         waited = 0;
        for (int i = 0; i < n; i++) begin
            if (!vr) begin
                vr = ($urandom_range(99) < vpct);
                va = 8'($urandom);
            end
            if (!cr) begin
                cr = ($urandom_range(99) < cpct);
                cw = 1'($urandom);
                ca = 8'($urandom_range(15));
                cd = 8'($urandom);
            end
            rn = !($urandom_range(99) < rpct);
            step(rn, vr, va, cr, cw, ca, cd, vg, cg);
            if (!rn) begin
                waited = 0;
            end else if (cr) begin
                waited++;
                if (cg) begin
                    chk_eq("cpu_wait_bound", (waited <= MAX + 1), 1);
                    waited = 0;
                end
            end
            if (vg) vr = 1'b0;
            if (cg) cr = 1'b0;
        end
    endtask

    initial begin
        bit vg;
        bit cg;
        reset_n     = 1'b0;
        vid_req     = 1'b1;
        vid_address = '0;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_address = '0;
        cpu_data    = '0;
        cyc         = 0;
        n_checks    = 0;
        n_pass      = 0;
        vid_run     = 0;
        exp_vid_rdata = 8'h00;
        exp_cpu_rdata = 8'h00;
        exp_ram_addr  = 8'h00;
        exp_ram_data  = 8'h00;
        exp_ram_we    = 1'b0;
        for (int a = 0; a < 256; a++) begin
            shadow[a] = 8'($urandom);
        end
        for (int a = 0; a < 8; a++) shadow[a] = 8'(8'h40 + a);
        shadow[8'h20] = 8'h77;
        shadow[8'h21] = 8'h88;
        for (int a = 0; a < 256; a++) ram_mem[a] = shadow[a];

        // Reset held with both requesters active
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h06, 8'h00, vg, cg);
        idle(2);

        // CPU write then read back
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 8'hA5, vg, cg);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, vg, cg);
        idle(5);
        chk_eq("wr_rd_0x12", cpu_rdata, 8'hA5);

        // Starvation guard: both held high
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b1, 1'b0, 8'h30, 8'h00, vg, cg);
            chk_eq("starve_pattern", vg, ((i % 5) != 4));
        end
        idle(4);

        // Back-to-back video reads
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 8'h00, vg, cg);
        idle(4);
        chk_eq("b2b_last", vid_rdata, 8'h47);

        // Interleave isolation
        step(1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00, 8'h00, vg, cg);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, vg, cg);
        idle(5);
        chk_eq("iso_vid", vid_rdata, 8'h88);
        chk_eq("iso_cpu", cpu_rdata, 8'h77);

        // Reset one cycle after a CPU read ack
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, vg, cg);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, vg, cg);
        idle(6);
        chk_eq("rst_mid_rdata", cpu_rdata, 8'h00);

        traffic(300, 60, 60, 0);
        traffic(400, 70, 50, 2);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester access arbiter placed in front of a single `spram` instance (one registered read/write port). It shares the RAM between a video scan-out reader and the CPU. One access issues per clock. Video has fixed priority, bounded by a starvation guard so the CPU always progresses. Requests and acknowledges are combinational, the RAM command is registered, and read data returns on a registered per-requester bus with a valid pulse.

## Interface
- DATA_WIDTH, 8, RAM word width; must match the attached `spram`.
- ADDRESS_WIDTH, 8, RAM address width.
- MAX_STREAK, 4, maximum number of consecutive video grants while the CPU is waiting. Legal range 1..255.

- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- vid_req  in  1  video read request; held with vid_address stable until vid_ack.
- vid_address  in  ADDRESS_WIDTH  video read address.
- vid_ack  out  1  combinational; high in the cycle the video request is granted.
- vid_rvalid  out  1  registered one-cycle pulse; vid_rdata is valid.
- vid_rdata  out  DATA_WIDTH  registered video read data.
- cpu_req  in  1  CPU request; cpu_we, cpu_address and cpu_data are held stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_address  in  ADDRESS_WIDTH  CPU address.
- cpu_data  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  combinational grant strobe.
- cpu_rvalid  out  1  registered one-cycle pulse, issued for reads only.
- cpu_rdata  out  DATA_WIDTH  registered CPU read data.
- ram_address  out  ADDRESS_WIDTH  registered RAM address.
- ram_data  out  DATA_WIDTH  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_q  in  DATA_WIDTH  RAM read output; one-cycle registered latency inside the RAM.

## Operation
- **Grant (combinational, cycle T):**
  - Only vid_req high: grant video.
  - Only cpu_req high: grant CPU.
  - Both high: grant video, unless streak == MAX_STREAK, in which case grant CPU.
  - Neither high: idle.
  - While reset_n = 0: no grant, so both acks are 0.
- **Streak counter:**
  - Increments on a video grant while cpu_req = 1.
  - Clears on any CPU grant, and on any cycle with cpu_req = 0.
  - Saturates at MAX_STREAK. Width is 8 bits.
- **Command register (end of T):**
  - On a grant: ram_address, ram_data and ram_we are loaded from the granted requester. Video always has we = 0; ram_data is loaded only on a CPU grant.
  - On idle: ram_we = 0; address and data hold their values.
- **Tag pipeline:**
  - Stage 1 records {valid, owner, is_read} at the end of T.
  - Stage 2 is a copy of stage 1 one cycle later.
  - When stage 2 is a valid read, at the end of T+2 the owner's rdata is loaded from ram_q and the owner's rvalid is pulsed for one cycle (T+3).
- **Writes:**
  - ack only; no rvalid is issued.
  - The RAM's write-through q is ignored.
- **rdata hold:** each rdata register holds its value until that requester's next read completes. The other requester's completions never disturb it.
- **Request handshake:**
  - The requester deasserts req or presents its next request in the cycle after ack.
  - req still high the cycle after ack is a new request. Back-to-back grants to the same requester are legal: one per cycle.

## Timing
- **Reset values:**
  - ram_address = 0, ram_data = 0, ram_we = 0.
  - vid_rdata = 0, cpu_rdata = 0.
  - vid_rvalid = 0, cpu_rvalid = 0.
  - streak = 0; tag pipeline invalid.
- **Latency:** a request acked in cycle T drives the RAM in T+1, ram_q is valid in T+2, and rvalid/rdata appear in T+3. Read latency from ack is 3 cycles.
- **Throughput:** 1 access per cycle with no bubbles. Completions leave in grant order.
- **Reset mid-operation:**
  - Asserting reset_n = 0 squashes all in-flight tags. No rvalid may appear for requests acked before reset.
  - First grant is possible in the first cycle with reset_n = 1.
- **Simultaneous events:** a completion for one requester coinciding with a grant to the other is legal. The rvalid pulse and ack occur independently.

## Test plan
- **Reset:** hold reset_n = 0 for 3 cycles with both req = 1 -> vid_ack = cpu_ack = 0, ram_we = 0, all rvalid = 0, rdata = 0.
- **CPU write then read:** CPU writes 0xA5 to 0x12 (ack in T, ram_we = 1 / address 0x12 / data 0xA5 in T+1), then reads 0x12 -> cpu_rvalid = 1 with cpu_rdata = 0xA5 exactly 3 cycles after the read ack; no cpu_rvalid after the write.
- **Starvation guard:** with MAX_STREAK = 4, vid_req and cpu_req held high continuously -> grant pattern V,V,V,V,C,V,V,V,V,C…; every CPU access is granted within 5 cycles.
- **Back-to-back video:** video reads 0x00..0x07 (preloaded with 0x40+addr) on consecutive cycles -> 8 consecutive vid_rvalid pulses with data 0x40..0x47 in order, latency 3 each.
- **Interleave isolation:** CPU read of 0x20 (value 0x77) granted in the cycle after a video read of 0x21 (0x88) -> vid_rvalid / 0x88 first, then cpu_rvalid / 0x77 one cycle later; vid_rdata remains 0x88.
- **Reset mid-flight:** reset_n = 0 one cycle after a CPU read ack -> no cpu_rvalid ever appears; cpu_rdata = 0.
